// File: rtl/ac97_cmd_sequencer.sv
// AC97 codec command sequencer: waits a number of frames after reset, writes a fixed
// init table one entry per frame, then issues master-volume / record-select updates.
module ac97_cmd_sequencer #(
    parameter int INIT_WAIT_FRAMES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ac97_ready_sig,
    input  logic        vol_req,
    input  logic [4:0]  vol_level,
    input  logic        vol_mute,
    input  logic        src_req,
    input  logic [2:0]  src_sel,
    output logic        latching_cmd,
    output logic [7:0]  cmd_addr,
    output logic [15:0] cmd_data,
    output logic        init_done,
    output logic        busy
);

    // state   | meaning
    // ST_WAIT | counting frame ticks after reset before the first command
    // ST_INIT | issuing init table entries, one per frame tick
    // ST_IDLE | init complete; issuing pending volume / source updates
    typedef enum logic [1:0] {
        ST_WAIT,
        ST_INIT,
        ST_IDLE
    } state_t;

    localparam logic [7:0] WAIT_FRAMES = 8'(INIT_WAIT_FRAMES);
    localparam logic [2:0] LAST_IDX    = 3'd6;

    state_t      state_q, state_d;
    logic        rdy_q;
    logic        tick;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic        vol_pend_q, vol_pend_d;
    logic [5:0]  vol_val_q, vol_val_d;
    logic        src_pend_q, src_pend_d;
    logic [2:0]  src_val_q, src_val_d;
    logic        vol_clr, src_clr;
    logic        issue;
    logic [7:0]  issue_addr;
    logic [15:0] issue_data;
    logic        done_d;
    logic [23:0] entry;

    function automatic logic [23:0] init_entry(input logic [2:0] i);
        logic [23:0] e;
        case (i)
            3'd0:    e = {8'h02, 16'h0000};
            3'd1:    e = {8'h04, 16'h0000};
            3'd2:    e = {8'h18, 16'h0808};
            3'd3:    e = {8'h1A, 16'h0404};
            3'd4:    e = {8'h1C, 16'h0000};
            3'd5:    e = {8'h0E, 16'h8008};
            default: e = {8'h10, 16'h0808};
        endcase
        return e;
    endfunction

    assign tick = ac97_ready_sig & ~rdy_q;

    // idx_q stays 0 throughout ST_WAIT, so one table lookup serves both states
    assign entry = init_entry(idx_q);

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        idx_d       = idx_q;
        issue       = 1'b0;
        issue_addr  = cmd_addr;
        issue_data  = cmd_data;
        done_d      = init_done;
        vol_clr     = 1'b0;
        src_clr     = 1'b0;

        case (state_q)
            ST_WAIT: begin
                if (tick) begin
                    if (frame_cnt_q == WAIT_FRAMES) begin
                        issue      = 1'b1;
                        issue_addr = entry[23:16];
                        issue_data = entry[15:0];
                        idx_d      = idx_q + 3'd1;
                        state_d    = ST_INIT;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end
                end
            end
            ST_INIT: begin
                if (tick) begin
                    issue      = 1'b1;
                    issue_addr = entry[23:16];
                    issue_data = entry[15:0];
                    if (idx_q == LAST_IDX) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            ST_IDLE: begin
                if (tick) begin
                    if (vol_pend_q) begin
                        issue      = 1'b1;
                        issue_addr = 8'h02;
                        issue_data = {vol_val_q[5], 2'b00, vol_val_q[4:0], 3'b000, vol_val_q[4:0]};
                        vol_clr    = 1'b1;
                    end else if (src_pend_q) begin
                        issue      = 1'b1;
                        issue_addr = 8'h1A;
                        issue_data = {5'b0, src_val_q, 5'b0, src_val_q};
                        src_clr    = 1'b1;
                    end
                end
            end
            default: state_d = ST_WAIT;
        endcase

        // a request landing on its own issue tick keeps the flag set with the new value
        vol_pend_d = vol_req | (vol_pend_q & ~vol_clr);
        vol_val_d  = vol_req ? {vol_mute, vol_level} : vol_val_q;
        src_pend_d = src_req | (src_pend_q & ~src_clr);
        src_val_d  = src_req ? src_sel : src_val_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_WAIT;
            rdy_q        <= 1'b0;
            frame_cnt_q  <= 8'd0;
            idx_q        <= 3'd0;
            vol_pend_q   <= 1'b0;
            vol_val_q    <= 6'd0;
            src_pend_q   <= 1'b0;
            src_val_q    <= 3'd0;
            latching_cmd <= 1'b0;
            cmd_addr     <= 8'h00;
            cmd_data     <= 16'h0000;
            init_done    <= 1'b0;
            busy         <= 1'b1;
        end else begin
            state_q      <= state_d;
            rdy_q        <= ac97_ready_sig;
            frame_cnt_q  <= frame_cnt_d;
            idx_q        <= idx_d;
            vol_pend_q   <= vol_pend_d;
            vol_val_q    <= vol_val_d;
            src_pend_q   <= src_pend_d;
            src_val_q    <= src_val_d;
            latching_cmd <= issue;
            cmd_addr     <= issue_addr;
            cmd_data     <= issue_data;
            init_done    <= done_d;
            busy         <= ~init_done | vol_pend_q | src_pend_q;
        end
    end

endmodule

// File: doc/ac97_cmd_sequencer.md
# ac97_cmd_sequencer

Control-side companion to the AC97 codec controller. After reset it waits a fixed number of AC97 frames, then writes a fixed initialisation table into the codec registers, one write per frame, through the controller's `latching_cmd` / `cmd_addr` / `cmd_data` command port. After that it issues run-time master-volume and record-source updates on request. It sits directly upstream of the controller's command inputs, and its frame timing comes from the controller's `ac97_ready_sig`.

## Interface
- `INIT_WAIT_FRAMES`, default 16: frame ticks to discard after reset before the first command (1..255).
- `clk`  in  1: system clock, the same clock as the codec controller.
- `reset`  in  1: reset. One clock; reset is synchronous and active-high.
- `ac97_ready_sig`  in  1: the controller's frame-ready level. Each rising edge is one frame tick.
- `vol_req`  in  1: one-cycle pulse requesting a master-volume write.
- `vol_level`  in  5: master attenuation, 0 = 0 dB, 31 = -46.5 dB. Sampled on `vol_req`.
- `vol_mute`  in  1: master mute bit. Sampled on `vol_req`.
- `src_req`  in  1: one-cycle pulse requesting a record-select write.
- `src_sel`  in  3: record source code. Sampled on `src_req`.
- `latching_cmd`  out  1: one-cycle strobe that presents a command to the controller.
- `cmd_addr`  out  8: codec register address.
- `cmd_data`  out  16: codec register data.
- `init_done`  out  1: high once the last init entry has been issued.
- `busy`  out  1: high while not yet initialised or while any request is pending.

## Operation
- **Frame tick.** `ac97_ready_sig` is registered into `rdy_q`. The tick is `ac97_ready_sig & ~rdy_q`. Every command is issued on a tick, so at most one command goes out per frame.
- **State `WAIT`** (entered from reset):
  - Each tick increments the frame counter.
  - On the tick that finds the counter equal to `INIT_WAIT_FRAMES`, issue init entry 0 and go to `INIT` with index 1.
- **State `INIT`:**
  - Each tick issues the entry at the current index, then increments the index.
  - Issuing index 6 sets `init_done` and moves to `IDLE`.
- **Init table** (address, data):
  - 0: 0x02, 0x0000 (master, 0 dB)
  - 1: 0x04, 0x0000 (headphone)
  - 2: 0x18, 0x0808 (PCM out)
  - 3: 0x1A, 0x0404 (record select = line)
  - 4: 0x1C, 0x0000 (record gain)
  - 5: 0x0E, 0x8008 (mic, muted)
  - 6: 0x10, 0x0808 (line in)
- **Request capture** (active in every state):
  - `vol_req` sets `vol_pend` and latches {mute, level}.
  - `src_req` sets `src_pend` and latches `src_sel`.
  - A repeat request while its flag is already set overwrites the latched value (latest wins). Only one command per type is ever issued for a pending flag.
- **State `IDLE`.** On a tick:
  - If `vol_pend`: issue address 0x02 with data {mute, 2'b00, level, 3'b000, level} and clear `vol_pend`.
  - Else if `src_pend`: issue address 0x1A with data {5'b0, sel, 5'b0, sel} and clear `src_pend`.
  - Else: issue nothing. Volume always has priority over source.
- **Pending before init.** Requests that arrive before `init_done` stay pending and are issued in `IDLE` after the init table completes.
- **Simultaneous request and tick.** A request in the same cycle as a tick is captured only; it is never issued on that tick. If it coincides with the tick that issues the same type, the old latched value is issued and the new value stays pending.
- **Busy.** `busy` = `~init_done | vol_pend | src_pend`, registered.
- **Reset** (at any time, including mid-table):
  - Return to `WAIT`.
  - Clear the counter, index and both pending flags.
  - Any partially completed init sequence restarts from entry 0.

## Timing
- **Reset values:** `latching_cmd` = 0, `cmd_addr` = 0x00, `cmd_data` = 0x0000, `init_done` = 0, `busy` = 1, `rdy_q` = 0.
- **Command issue latency:**
  - A tick detected in cycle T produces registered `cmd_addr` / `cmd_data` and `latching_cmd` = 1 in cycle T+1.
  - `latching_cmd` returns to 0 in cycle T+2.
- **Hold:** `cmd_addr` / `cmd_data` stay stable until the next issue.
- **`init_done` timing:** rises in the same cycle as the strobe for entry 6, then stays high until reset.
- **Ready level:** `ac97_ready_sig` held high for many cycles yields exactly one tick.

## Test plan
- **Init sequence.** `INIT_WAIT_FRAMES` = 2, ready edges every 256 clk. Expect no strobes on ticks 1–2. Ticks 3–9 strobe addresses 0x02, 0x04, 0x18, 0x1A, 0x1C, 0x0E, 0x10 with the table data. `init_done` rises with the 0x10 strobe, and `busy` falls the cycle after.
- **Volume write.** In `IDLE`, `vol_req` with level = 5, mute = 1. The next tick strobes 0x02 / 0x8505, strobe width exactly 1 cycle. `busy` is high from the request until the issue.
- **Priority and overwrite.** Send `src_req` with sel = 3, then `vol_req` level 1, then `vol_req` level 9, all in one frame. Tick 1 issues 0x02 / 0x0909. Tick 2 issues 0x1A / 0x0303. Tick 3 issues nothing.
- **Early request.** `vol_req` level 31 during `WAIT`. It is issued as 0x02 / 0x1F1F on the first tick after entry 6.
- **Same-cycle coincidence.** `vol_req` level 2 in the same cycle as the tick that issues pending level 7. Expect 0x0707 now, then 0x0202 on the next tick.
- **Reset mid-table.** Assert `reset` for 1 cycle after entry 3 is issued. All outputs go to their reset values, and the sequence restarts with the wait and entry 0. A ready level held high for 1000 cycles produces one tick only.
